// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the single register-file write port between the writeback stage (WB),
// the jal link write (LNK) and the multiply/divide unit (MDU). At most one real
// write is granted per cycle and presented on a registered write port one clock
// later. Writes aimed at gr0 are acknowledged immediately and never reach the
// port. A per-register scoreboard tracks MDU destinations that are still
// outstanding so the hazard unit can stall dependent reads.
//
// Handshake: a requester transfers in any cycle where its valid and ready are
// both 1. Each ready is combinational from the current valids, the request
// destinations and starve_cnt. A requester keeps valid and its payload stable
// until it is granted. All readies are forced to 0 while RSTn is low.
module rf_write_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int NREG         = 32
) (
   input  logic            CLK,
   input  logic            RSTn,
   // writeback stage
   input  logic            wb_valid,
   input  logic [4:0]      wb_num,
   input  logic [31:0]     wb_data,
   output logic            wb_ready,
   // jal link write, always to gr31
   input  logic            lnk_valid,
   input  logic [31:0]     lnk_pc,
   output logic            lnk_ready,
   // multiply/divide unit
   input  logic            mdu_issue,
   input  logic [4:0]      mdu_issue_num,
   input  logic            mdu_valid,
   input  logic [4:0]      mdu_num,
   input  logic [31:0]     mdu_data,
   output logic            mdu_ready,
   // registered write port
   output logic            RegWriteW,
   output logic [4:0]      WriteRegW,
   output logic [31:0]     wr_data,
   // scoreboard and debug
   output logic [NREG-1:0] pending,
   output logic [2:0]      starve_cnt
);

   // Source that owns the write port this cycle; exposed internally so a
   // checker can bind to it.
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_WB   = 2'd1,
      SRC_LNK  = 2'd2,
      SRC_MDU  = 2'd3
   } src_e;

   localparam logic [4:0] LNK_REG    = 5'd31;
   localparam logic [4:0] ZERO_REG   = 5'd0;
   localparam logic [2:0] STARVE_MAX = 3'd7;
   localparam logic [2:0] STARVE_THR = 3'(STARVE_LIMIT);

   // state
   logic            regwrite_q,   regwrite_d;
   logic [4:0]      write_reg_q,  write_reg_d;
   logic [31:0]     wr_data_q,    wr_data_d;
   logic [NREG-1:0] pending_q,    pending_d;
   logic [2:0]      starve_cnt_q, starve_cnt_d;

   // request classification
   logic wb_real;    // WB wants the port
   logic wb_drop;    // WB targets gr0, acknowledged without a write
   logic mdu_real;   // MDU wants the port
   logic mdu_drop;   // MDU targets gr0, acknowledged without a write
   logic mdu_urgent; // MDU has lost often enough to jump the queue
   src_e winner;

   // grants before reset gating
   logic wb_gnt;
   logic lnk_gnt;
   logic mdu_gnt;

   // Classify the requests and pick the port owner: WB > LNK > MDU, except a
   // starved MDU request takes the port ahead of both.
   always_comb begin
      wb_real    = wb_valid && (wb_num != ZERO_REG);
      wb_drop    = wb_valid && (wb_num == ZERO_REG);
      mdu_real   = mdu_valid && (mdu_num != ZERO_REG);
      mdu_drop   = mdu_valid && (mdu_num == ZERO_REG);
      mdu_urgent = mdu_real && (starve_cnt_q >= STARVE_THR);
      winner     = SRC_NONE;
      if (mdu_urgent) begin
         winner = SRC_MDU;
      end else if (wb_real) begin
         winner = SRC_WB;
      end else if (lnk_valid) begin
         winner = SRC_LNK;
      end else if (mdu_real) begin
         winner = SRC_MDU;
      end
   end

   // Grants: the port winner plus any gr0 request, which never competes.
   always_comb begin
      wb_gnt  = wb_drop || (winner == SRC_WB);
      lnk_gnt = (winner == SRC_LNK);
      mdu_gnt = mdu_drop || (winner == SRC_MDU);
   end

   assign wb_ready  = RSTn && wb_gnt;
   assign lnk_ready = RSTn && lnk_gnt;
   assign mdu_ready = RSTn && mdu_gnt;

   // Next write-port contents: load the winner, otherwise drop the enable and
   // keep address/data as they were.
   always_comb begin
      regwrite_d  = 1'b0;
      write_reg_d = write_reg_q;
      wr_data_d   = wr_data_q;
      case (winner)
         SRC_WB: begin
            regwrite_d  = 1'b1;
            write_reg_d = wb_num;
            wr_data_d   = wb_data;
         end
         SRC_LNK: begin
            regwrite_d  = 1'b1;
            write_reg_d = LNK_REG;
            wr_data_d   = lnk_pc;
         end
         SRC_MDU: begin
            regwrite_d  = 1'b1;
            write_reg_d = mdu_num;
            wr_data_d   = mdu_data;
         end
         default: begin
            regwrite_d  = 1'b0;
         end
      endcase
   end

   // Starvation counter: counts consecutive cycles a real MDU request loses,
   // saturating; any MDU grant or an idle MDU clears it.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!mdu_valid || mdu_gnt) begin
         starve_cnt_d = 3'd0;
      end else if (mdu_real && (starve_cnt_q != STARVE_MAX)) begin
         starve_cnt_d = starve_cnt_q + 3'd1;
      end
   end

   // Scoreboard: a granted MDU result retires its destination, a new issue
   // marks one outstanding. The issue is applied last so it wins a same-register
   // collision. gr0 is never outstanding.
   always_comb begin
      pending_d = pending_q;
      if (mdu_gnt && mdu_real) begin
         pending_d[mdu_num] = 1'b0;
      end
      if (mdu_issue && (mdu_issue_num != ZERO_REG)) begin
         pending_d[mdu_issue_num] = 1'b1;
      end
      pending_d[0] = 1'b0;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         regwrite_q   <= 1'b0;
         write_reg_q  <= 5'd0;
         wr_data_q    <= 32'd0;
         pending_q    <= '0;
         starve_cnt_q <= 3'd0;
      end else begin
         regwrite_q   <= regwrite_d;
         write_reg_q  <= write_reg_d;
         wr_data_q    <= wr_data_d;
         pending_q    <= pending_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign RegWriteW  = regwrite_q;
   assign WriteRegW  = write_reg_q;
   assign wr_data    = wr_data_q;
   assign pending    = pending_q;
   assign starve_cnt = starve_cnt_q;

endmodule
